// File: rtl/b_resp_router_pkg.sv
// Shared constants and helpers for the ordered B-response router.
package b_resp_router_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index of the highest set bit among the low n bits; 0 when none set.
  function automatic int unsigned onehot_to_idx(input logic [255:0] vec, input int unsigned n);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < int'(n) && vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/b_order_fifo.sv
// In-order tracking FIFO of master indices; push when full / pop when empty are ignored.
module b_order_fifo
  import b_resp_router_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy tracking; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care while not occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/b_resp_router.sv
// Ordered AXI-Lite B-response router: records the issuing master of each AW and
// steers returning B responses to the oldest outstanding master.
// Optional output register: define B_RESP_ROUTER_OUT_REG_EN.
module b_resp_router
  import b_resp_router_pkg::*;
#(
  parameter int TRANS_WR_RESP_W = 2,
  parameter int NUM_MASTERS     = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = (clog2(NUM_MASTERS) > 1) ? clog2(NUM_MASTERS) : 1,
  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   aw_push_valid_i,
  input  logic [NUM_MASTERS-1:0]                 aw_push_master_i,
  output logic                                   aw_push_ready_o,
  input  logic [TRANS_WR_RESP_W-1:0]             s_axi_bresp_i,
  input  logic                                   s_axi_bvalid_i,
  output logic                                   s_axi_bready_o,
  output logic [TRANS_WR_RESP_W*NUM_MASTERS-1:0] m_axi_bresp_o,
  output logic [NUM_MASTERS-1:0]                 m_axi_bvalid_o,
  input  logic [NUM_MASTERS-1:0]                 m_axi_bready_i,
  output logic [CNT_W-1:0]                       outstanding_cnt_o,
  output logic                                   err_unexpected_b_o
);

  localparam int W = TRANS_WR_RESP_W;

  logic [255:0]     push_vec;
  logic [IDX_W-1:0] push_idx, head;
  logic             full, empty, s_accept, drop, err_q;

  assign push_vec = 256'(aw_push_master_i);
  assign push_idx = IDX_W'(onehot_to_idx(push_vec, NUM_MASTERS));

  b_order_fifo #(.DATA_W(IDX_W), .DEPTH(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (aw_push_valid_i),
    .data_i  (push_idx),
    .pop_i   (s_accept),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_cnt_o)
  );

  assign aw_push_ready_o    = !full;
  assign s_accept           = s_axi_bvalid_i && s_axi_bready_o && !empty;
  assign drop               = s_axi_bvalid_i && s_axi_bready_o && empty;
  assign err_unexpected_b_o = err_q;

  // Unexpected-response pulse, one cycle after the dropped B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= drop;
  end

`ifdef B_RESP_ROUTER_OUT_REG_EN
  // Output register kept in decoded form so every m_axi_* bit is a flop.
  logic [NUM_MASTERS-1:0]   bvalid_q;
  logic [W*NUM_MASTERS-1:0] bresp_q;
  logic                     unload_ok;

  assign unload_ok      = (bvalid_q == '0) || ((bvalid_q & m_axi_bready_i) != '0);
  assign s_axi_bready_o = empty ? !aw_push_valid_i : unload_ok;
  assign m_axi_bvalid_o = bvalid_q;
  assign m_axi_bresp_o  = bresp_q;

  // Load on slave acceptance, clear on master handshake; load wins for back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= '0;
      bresp_q  <= '0;
    end else if (s_accept) begin
      bvalid_q <= '0;
      bresp_q  <= '0;
      bvalid_q[head] <= 1'b1;
      bresp_q[int'(head)*W +: W] <= s_axi_bresp_i;
    end else if ((bvalid_q & m_axi_bready_i) != '0) begin
      bvalid_q <= '0;
      bresp_q  <= '0;
    end
  end
`else
  assign s_axi_bready_o = empty ? !aw_push_valid_i : m_axi_bready_i[head];

  // Pass-through steering of the slave B to the head master only.
  always_comb begin
    m_axi_bvalid_o = '0;
    m_axi_bresp_o  = '0;
    if (!empty) begin
      m_axi_bvalid_o[head]              = s_axi_bvalid_i;
      m_axi_bresp_o[int'(head)*W +: W]  = s_axi_bresp_i;
    end
  end
`endif

endmodule

// File: tb/tb_b_resp_router.sv
// Directed bench for b_resp_router (pass-through build; test 1 also covers the registered build).
module tb_b_resp_router;
  import b_resp_router_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_push_valid_i;
  logic [15:0] aw_push_master_i;
  logic        aw_push_ready_o;
  logic [1:0]  s_axi_bresp_i;
  logic        s_axi_bvalid_i;
  logic        s_axi_bready_o;
  logic [31:0] m_axi_bresp_o;
  logic [15:0] m_axi_bvalid_o;
  logic [15:0] m_axi_bready_i;
  logic [2:0]  outstanding_cnt_o;
  logic        err_unexpected_b_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  b_resp_router #(.TRANS_WR_RESP_W(2), .NUM_MASTERS(16), .MAX_OUTSTANDING(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .aw_push_valid_i    (aw_push_valid_i),
    .aw_push_master_i   (aw_push_master_i),
    .aw_push_ready_o    (aw_push_ready_o),
    .s_axi_bresp_i      (s_axi_bresp_i),
    .s_axi_bvalid_i     (s_axi_bvalid_i),
    .s_axi_bready_o     (s_axi_bready_o),
    .m_axi_bresp_o      (m_axi_bresp_o),
    .m_axi_bvalid_o     (m_axi_bvalid_o),
    .m_axi_bready_i     (m_axi_bready_i),
    .outstanding_cnt_o  (outstanding_cnt_o),
    .err_unexpected_b_o (err_unexpected_b_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] m);
    aw_push_valid_i  = 1'b1;
    aw_push_master_i = m;
    step();
    aw_push_valid_i  = 1'b0;
    aw_push_master_i = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_awrdy"},  aw_push_ready_o, 1);
    check({tag, "_bready"}, s_axi_bready_o, 1);
    check({tag, "_mvalid"}, m_axi_bvalid_o, 0);
    check({tag, "_mresp"},  m_axi_bresp_o, 0);
    check({tag, "_cnt"},    outstanding_cnt_o, 0);
    check({tag, "_err"},    err_unexpected_b_o, 0);
  endtask

  logic [3:0] exp_m [4];
  logic [1:0] exp_r [4];

  initial begin
    rst_n = 1'b0;
    aw_push_valid_i = 1'b0; aw_push_master_i = '0;
    s_axi_bresp_i = '0; s_axi_bvalid_i = 1'b0; m_axi_bready_i = '0;
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Test 1: single write to master 5, SLVERR.
    aw_push_valid_i = 1'b1; aw_push_master_i = 16'h0020;
    #1;
    check("t1_bready_empty_push", s_axi_bready_o, 0);
    step();
    aw_push_valid_i = 1'b0; aw_push_master_i = '0;
    #1;
    check("t1_cnt1", outstanding_cnt_o, 1);
    s_axi_bvalid_i = 1'b1; s_axi_bresp_i = RESP_SLVERR; m_axi_bready_i = 16'h0020;
    #1;
`ifdef B_RESP_ROUTER_OUT_REG_EN
    check("t1_mvalid_pre", m_axi_bvalid_o, 16'h0000);
    check("t1_bready", s_axi_bready_o, 1);
    step();
    s_axi_bvalid_i = 1'b0;
    #1;
`else
    check("t1_bready", s_axi_bready_o, 1);
`endif
    check("t1_mvalid", m_axi_bvalid_o, 16'h0020);
    check("t1_resp5", m_axi_bresp_o[11:10], 2'b10);
    check("t1_respvec", m_axi_bresp_o, 32'h0000_0800);
    step();
    s_axi_bvalid_i = 1'b0; m_axi_bready_i = '0;
    #1;
    check("t1_cnt0", outstanding_cnt_o, 0);
    check("t1_err", err_unexpected_b_o, 0);
`ifdef B_RESP_ROUTER_OUT_REG_EN
    check("t1_mvalid_clr", m_axi_bvalid_o, 16'h0000);
`endif

`ifndef B_RESP_ROUTER_OUT_REG_EN
    // Test 2: fill to depth, fifth push ignored, in-order returns.
    exp_m[0] = 4'd3; exp_m[1] = 4'd7; exp_m[2] = 4'd0; exp_m[3] = 4'd12;
    exp_r[0] = RESP_OKAY; exp_r[1] = RESP_EXOKAY; exp_r[2] = RESP_SLVERR; exp_r[3] = RESP_DECERR;
    for (int k = 0; k < 4; k++) push(16'h0001 << exp_m[k]);
    check("t2_cnt_full", outstanding_cnt_o, 4);
    check("t2_awrdy_full", aw_push_ready_o, 0);
    push(16'h0002);
    check("t2_cnt_after_5th", outstanding_cnt_o, 4);
    m_axi_bready_i = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      s_axi_bvalid_i = 1'b1; s_axi_bresp_i = exp_r[k];
      #1;
      check($sformatf("t2_mvalid%0d", k), m_axi_bvalid_o, 16'h0001 << exp_m[k]);
      check($sformatf("t2_mresp%0d", k), m_axi_bresp_o, 32'(exp_r[k]) << (2 * exp_m[k]));
      step();
    end
    s_axi_bvalid_i = 1'b0; m_axi_bready_i = '0;
    check("t2_cnt0", outstanding_cnt_o, 0);

    // Test 3: backpressure from master 2 for three cycles.
    push(16'h0004);
    s_axi_bvalid_i = 1'b1; s_axi_bresp_i = RESP_DECERR; m_axi_bready_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_bready%0d", k), s_axi_bready_o, 0);
      check($sformatf("t3_mvalid%0d", k), m_axi_bvalid_o, 16'h0004);
      check($sformatf("t3_mresp%0d", k), m_axi_bresp_o, 32'h0000_0030);
      step();
      check($sformatf("t3_cnt%0d", k), outstanding_cnt_o, 1);
    end
    m_axi_bready_i = 16'h0004;
    #1;
    check("t3_bready_go", s_axi_bready_o, 1);
    step();
    s_axi_bvalid_i = 1'b0; m_axi_bready_i = '0;
    check("t3_cnt0", outstanding_cnt_o, 0);

    // Test 4: unexpected B with nothing outstanding.
    s_axi_bvalid_i = 1'b1; s_axi_bresp_i = RESP_EXOKAY;
    #1;
    check("t4_bready", s_axi_bready_o, 1);
    check("t4_mvalid", m_axi_bvalid_o, 0);
    check("t4_err_pre", err_unexpected_b_o, 0);
    step();
    s_axi_bvalid_i = 1'b0;
    check("t4_err_pulse", err_unexpected_b_o, 1);
    step();
    check("t4_err_clear", err_unexpected_b_o, 0);
    check("t4_cnt", outstanding_cnt_o, 0);

    // Test 5: multi-hot push, then simultaneous push/pop at count 2.
    push(16'h0003);
    push(16'h0010);
    check("t5_cnt2", outstanding_cnt_o, 2);
    m_axi_bready_i = 16'hFFFF;
    aw_push_valid_i = 1'b1; aw_push_master_i = 16'h0200;
    s_axi_bvalid_i = 1'b1; s_axi_bresp_i = RESP_OKAY;
    #1;
    check("t5_head_m1", m_axi_bvalid_o, 16'h0002);
    step();
    aw_push_valid_i = 1'b0; aw_push_master_i = '0;
    check("t5_cnt_pp", outstanding_cnt_o, 2);
    #1;
    check("t5_head_m4", m_axi_bvalid_o, 16'h0010);
    step();
    #1;
    check("t5_head_m9", m_axi_bvalid_o, 16'h0200);
    step();
    s_axi_bvalid_i = 1'b0; m_axi_bready_i = '0;
    check("t5_cnt0", outstanding_cnt_o, 0);

    // Test 6: asynchronous reset with 3 outstanding and a B pending.
    push(16'h0002); push(16'h0004); push(16'h0008);
    check("t6_cnt3", outstanding_cnt_o, 3);
    s_axi_bvalid_i = 1'b1; s_axi_bresp_i = RESP_SLVERR; m_axi_bready_i = '0;
    #1;
    check("t6_mvalid_pre", m_axi_bvalid_o, 16'h0002);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    #1;
    rst_n = 1'b1;
    step();
    check("t6_err_after", err_unexpected_b_o, 1);
    check("t6_mvalid_after", m_axi_bvalid_o, 0);
    s_axi_bvalid_i = 1'b0;
    step();
    check("t6_err_clear", err_unexpected_b_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
